// File: rtl/branch_cmp_unit.sv
// branch_cmp_unit: multi-cycle MSB-first chunked comparator producing branch conditions over valid/ready
module branch_cmp_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             eq_o,
    output logic             ltu_o,
    output logic             lts_o
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       mode_r;
    logic [IW-1:0]    idx;
    logic             decided, ltu_acc, sign_diff;
    logic [CHUNK-1:0] a_c, b_c;
    logic             dec_n, ltu_n, lts_n, res_n;

    // The first differing chunk from the MSB end fixes the unsigned ordering
    always_comb begin
        a_c   = a_r[int'(idx) * CHUNK +: CHUNK];
        b_c   = b_r[int'(idx) * CHUNK +: CHUNK];
        dec_n = decided | (a_c != b_c);
        ltu_n = decided ? ltu_acc : (a_c < b_c);
        lts_n = sign_diff ? a_r[WIDTH-1] : ltu_n;
        res_n = mode_r[2] ? ((mode_r[1] ? ltu_n : lts_n) ^ mode_r[0])
                          : (!mode_r[1] & (!dec_n ^ mode_r[0]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= 1'b0;
            eq_o      <= 1'b0;
            ltu_o     <= 1'b0;
            lts_o     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            mode_r    <= '0;
            idx       <= '0;
            decided   <= 1'b0;
            ltu_acc   <= 1'b0;
            sign_diff <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r       <= a;
                    b_r       <= b;
                    mode_r    <= mode;
                    idx       <= IW'(N - 1);
                    decided   <= 1'b0;
                    ltu_acc   <= 1'b0;
                    sign_diff <= a[WIDTH-1] ^ b[WIDTH-1];
                    in_ready  <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    decided <= dec_n;
                    ltu_acc <= ltu_n;
                    if (idx == '0) begin
                        eq_o      <= !dec_n;
                        ltu_o     <= ltu_n;
                        lts_o     <= lts_n;
                        result    <= res_n;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_cmp_unit.sv
// tb_branch_cmp_unit: directed-vector bench for branch_cmp_unit and two parameter variants
module tb_branch_cmp_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  mode = '0;
    logic        in_ready, out_valid, result, eq_o, ltu_o, lts_o;

    branch_cmp_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .eq_o(eq_o), .ltu_o(ltu_o), .lts_o(lts_o)
    );

    logic        v1_in_valid = 1'b0;
    logic [15:0] v1_a = '0, v1_b = '0;
    logic [2:0]  v1_mode = '0;
    logic        v1_in_ready, v1_out_valid, v1_result, v1_eq, v1_ltu, v1_lts;

    branch_cmp_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v1_in_valid), .in_ready(v1_in_ready), .a(v1_a), .b(v1_b),
        .mode(v1_mode), .out_valid(v1_out_valid), .out_ready(1'b1), .result(v1_result),
        .eq_o(v1_eq), .ltu_o(v1_ltu), .lts_o(v1_lts)
    );

    logic        v2_in_valid = 1'b0;
    logic [63:0] v2_a = '0, v2_b = '0;
    logic [2:0]  v2_mode = '0;
    logic        v2_in_ready, v2_out_valid, v2_result, v2_eq, v2_ltu, v2_lts;

    branch_cmp_unit #(.WIDTH(64), .CHUNK(8)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v2_in_valid), .in_ready(v2_in_ready), .a(v2_a), .b(v2_b),
        .mode(v2_mode), .out_valid(v2_out_valid), .out_ready(1'b1), .result(v2_result),
        .eq_o(v2_eq), .ltu_o(v2_ltu), .lts_o(v2_lts)
    );

    localparam logic [2:0] EQ = 3'b000, NE = 3'b001, RSV = 3'b010, LT = 3'b100,
                           GE = 3'b101, LTU = 3'b110, GEU = 3'b111;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] m);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", in_ready, 1);
        a = av;
        b = bv;
        mode = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic r, input logic e, input logic lu,
                           input logic ls, input logic rel);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 4);
        chk({tag, "_res"}, result, r);
        chk({tag, "_eq"}, eq_o, e);
        chk({tag, "_ltu"}, ltu_o, lu);
        chk({tag, "_lts"}, lts_o, ls);
        if (rel) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out", {out_valid, result, eq_o, ltu_o, lts_o}, 0);
        rst = 1'b0;
        tick();

        send(32'h12345678, 32'h12345678, EQ);
        collect("eq", 1, 1, 0, 0, 1);
        send(32'h12345678, 32'h12345678, NE);
        collect("ne", 0, 1, 0, 0, 1);

        send(32'h80000000, 32'h00000001, LT);
        collect("sgn_lt", 1, 0, 0, 1, 1);
        send(32'h80000000, 32'h00000001, LTU);
        collect("sgn_ltu", 0, 0, 0, 1, 1);
        send(32'h80000000, 32'h00000001, GEU);
        collect("sgn_geu", 1, 0, 0, 1, 1);

        send(32'hFFFFFF00, 32'hFFFFFF01, LTU);
        collect("lsb_ltu", 1, 0, 1, 1, 1);
        send(32'hFFFFFF02, 32'hFFFFFF01, LTU);
        collect("lsb2_ltu", 0, 0, 0, 0, 1);
        send(32'hFFFFFF02, 32'hFFFFFF01, GE);
        collect("lsb2_ge", 1, 0, 0, 0, 1);

        send(32'd1, 32'd2, RSV);
        collect("rsv", 0, 0, 1, 1, 1);

        // Stall the consumer while a new request waits on the bus
        send(32'd3, 32'd7, LTU);
        collect("bp", 1, 0, 1, 1, 0);
        a = 32'd9;
        b = 32'd9;
        mode = EQ;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", {out_valid, in_ready, result, eq_o, ltu_o, lts_o}, 6'b101011);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle", {out_valid, in_ready}, 2'b01);
        tick();
        in_valid = 1'b0;
        chk("bp_taken", in_ready, 0);
        collect("bp_next", 1, 1, 0, 0, 1);

        send(32'd10, 32'd20, LTU);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid", {out_valid, in_ready}, 2'b01);
        tick();
        rst = 1'b0;
        send(32'd5, 32'd3, GE);
        collect("post_rst", 1, 0, 0, 0, 1);

        v1_a = 16'h8000;
        v1_b = 16'h0001;
        v1_mode = LT;
        v1_in_valid = 1'b1;
        tick();
        v1_in_valid = 1'b0;
        chk("v16_busy", v1_in_ready, 0);
        tick();
        chk("v16_valid", v1_out_valid, 1);
        chk("v16_res", {v1_result, v1_eq, v1_ltu, v1_lts}, 4'b1001);

        v2_a = 64'h8000_0000_0000_0000;
        v2_b = 64'h0;
        v2_mode = LT;
        v2_in_valid = 1'b1;
        tick();
        v2_in_valid = 1'b0;
        begin
            int n = 0;
            while (!v2_out_valid && n < 30) begin
                tick();
                n++;
            end
            chk("v64_lat", 64'(n), 8);
        end
        chk("v64_res", {v2_result, v2_eq, v2_ltu, v2_lts}, 4'b1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
